// File: rtl/comparator_1_bit_gate_level_core.sv
// 1-bit magnitude comparator built from gate primitives, with registered
// one-hot result flags, a valid flag and saturating per-outcome counters.

// Saturating up-counter with synchronous clear; clear wins over increment.
module comparator_1_bit_gate_level_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

module comparator_1_bit_gate_level_core #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             cnt_clr,
  output logic             A_equals_B,
  output logic             A_greater_B,
  output logic             A_less_B,
  output logic             out_valid,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count
);

  // Combinational outcome, gate primitives only.
  logic a_n;
  logic b_n;
  logic eq_c;
  logic gt_c;
  logic lt_c;

  not  g_a_n (a_n, A);
  not  g_b_n (b_n, B);
  xnor g_eq  (eq_c, A, B);
  and  g_gt  (gt_c, A, b_n);
  and  g_lt  (lt_c, a_n, B);

  logic eq_q;
  logic gt_q;
  logic lt_q;
  logic valid_q;

  // Sample the outcome every edge; valid latches high after the first edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      eq_q    <= eq_c;
      gt_q    <= gt_c;
      lt_q    <= lt_c;
      valid_q <= 1'b1;
    end
  end

  assign A_equals_B  = eq_q;
  assign A_greater_B = gt_q;
  assign A_less_B    = lt_q;
  assign out_valid   = valid_q;

  // Counters follow the combinational outcome so they advance on the same
  // edge that registers the matching flag.
  comparator_1_bit_gate_level_sat_cnt #(.CNT_W(CNT_W)) u_eq_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .inc_i (eq_c),
    .cnt_o (eq_count)
  );

  comparator_1_bit_gate_level_sat_cnt #(.CNT_W(CNT_W)) u_gt_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .inc_i (gt_c),
    .cnt_o (gt_count)
  );

  comparator_1_bit_gate_level_sat_cnt #(.CNT_W(CNT_W)) u_lt_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .inc_i (lt_c),
    .cnt_o (lt_count)
  );

endmodule

// File: tb/tb_comparator_1_bit_gate_level_core.sv
// Bench for comparator_1_bit_gate_level_core: a default-width instance and a
// 2-bit-counter instance share stimulus and are checked against a model
// that keeps unbounded outcome tallies and clips them to each width.
module tb_comparator_1_bit_gate_level_core;

  logic clk = 1'b0;
  logic rst;
  logic A;
  logic B;
  logic cnt_clr;

  logic       eq0, gt0, lt0, v0;
  logic [7:0] ec0, gc0, lc0;
  logic       eq1, gt1, lt1, v1;
  logic [1:0] ec1, gc1, lc1;

  int checks = 0;
  int errors = 0;

  // Model state.
  int n_eq, n_gt, n_lt;
  logic x_eq, x_gt, x_lt, x_valid;

  always #5 clk = ~clk;

  comparator_1_bit_gate_level_core u_dut8 (
    .clk(clk), .rst(rst), .A(A), .B(B), .cnt_clr(cnt_clr),
    .A_equals_B(eq0), .A_greater_B(gt0), .A_less_B(lt0), .out_valid(v0),
    .eq_count(ec0), .gt_count(gc0), .lt_count(lc0)
  );

  comparator_1_bit_gate_level_core #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .cnt_clr(cnt_clr),
    .A_equals_B(eq1), .A_greater_B(gt1), .A_less_B(lt1), .out_valid(v1),
    .eq_count(ec1), .gt_count(gc1), .lt_count(lc1)
  );

  function automatic int clip(input int n, input int w);
    int cap;
    cap = (1 << w) - 1;
    return (n > cap) ? cap : n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".eq8"}, int'(eq0), int'(x_eq));
    check({tag, ".gt8"}, int'(gt0), int'(x_gt));
    check({tag, ".lt8"}, int'(lt0), int'(x_lt));
    check({tag, ".valid8"}, int'(v0), int'(x_valid));
    check({tag, ".eqcnt8"}, int'(ec0), clip(n_eq, 8));
    check({tag, ".gtcnt8"}, int'(gc0), clip(n_gt, 8));
    check({tag, ".ltcnt8"}, int'(lc0), clip(n_lt, 8));
    check({tag, ".eq2"}, int'(eq1), int'(x_eq));
    check({tag, ".gt2"}, int'(gt1), int'(x_gt));
    check({tag, ".lt2"}, int'(lt1), int'(x_lt));
    check({tag, ".valid2"}, int'(v1), int'(x_valid));
    check({tag, ".eqcnt2"}, int'(ec1), clip(n_eq, 2));
    check({tag, ".gtcnt2"}, int'(gc1), clip(n_gt, 2));
    check({tag, ".ltcnt2"}, int'(lc1), clip(n_lt, 2));
    if (v0 === 1'b1)
      check({tag, ".onehot8"}, int'(eq0) + int'(gt0) + int'(lt0), 1);
  endtask

  task automatic model_reset();
    n_eq = 0; n_gt = 0; n_lt = 0;
    x_eq = 0; x_gt = 0; x_lt = 0; x_valid = 0;
  endtask

  // One rising edge: model samples the inputs present at the edge, outputs
  // are checked 1 time unit later.
  task automatic tick(input string tag);
    int ia, ib;
    @(posedge clk);
    ia = int'(A); ib = int'(B);
    if (!rst) begin
      x_eq = (ia == ib);
      x_gt = (ia > ib);
      x_lt = (ia < ib);
      x_valid = 1'b1;
      if (cnt_clr) begin
        n_eq = 0; n_gt = 0; n_lt = 0;
      end else if (ia == ib) n_eq++;
      else if (ia > ib) n_gt++;
      else n_lt++;
    end
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges (caller is just past an edge).
  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [1:0] pat;
    rst = 1'b1; A = 1'b0; B = 1'b0; cnt_clr = 1'b0;
    model_reset();
    #2 check_all("rst_no_clk");
    @(posedge clk); @(posedge clk); #1;
    check_all("rst_held");
    #1 rst = 1'b0;

    // First edge after reset with (0,0).
    A = 0; B = 0;
    tick("first_eq");

    // Truth-table walk from a fresh reset.
    mid_reset("rst_tt");
    for (int unsigned i = 0; i < 4; i++) begin
      pat = 2'(i);
      A = pat[1]; B = pat[0];
      tick($sformatf("tt%0d", i));
    end

    // Saturation of the 2-bit instance with A>B held.
    @(negedge clk);
    rst = 1'b1; #1 model_reset(); rst = 1'b0;
    A = 1; B = 0;
    for (int unsigned i = 0; i < 5; i++) tick($sformatf("sat%0d", i));
    check("sat.gt2_final", int'(gc1), 3);

    // Clear coincident with a less-than sample.
    A = 0; B = 1; cnt_clr = 1'b1;
    tick("clr_lt");
    cnt_clr = 1'b0;

    // Build nonzero counts with flags 010, then async reset between edges.
    A = 1; B = 0; tick("pre_rst_a");
    tick("pre_rst_b");
    mid_reset("mid_rst");
    A = 0; B = 1;
    tick("post_rst");

    // Toggle A between edges; outputs must not move.
    #1 A = ~A; #1 check_all("toggle_a");
    #1 A = ~A; #1 check_all("toggle_b");
    #1 A = ~A; #1 check_all("toggle_c");

    // Randomized run with occasional clears and mid-cycle resets.
    for (int unsigned i = 0; i < 300; i++) begin
      A = 1'($urandom_range(0, 1));
      B = 1'($urandom_range(0, 1));
      cnt_clr = ($urandom_range(0, 15) == 0);
      tick("rand");
      cnt_clr = 1'b0;
      if ($urandom_range(0, 49) == 0) mid_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_1_bit_gate_level_core.md
COMPARATOR_1_BIT_GATE_LEVEL_CORE -- requirements
Module: comparator_1_bit_gate_level

Interface
REQ-001 Parameter: CNT_W, default 8, width of each outcome counter, legal range 2..16.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 A  input  1  operand A.
REQ-005 B  input  1  operand B.
REQ-006 cnt_clr  input  1  synchronous clear of all outcome counters.
REQ-007 A_equals_B  output  1  registered flag, A == B.
REQ-008 A_greater_B  output  1  registered flag, A > B.
REQ-009 A_less_B  output  1  registered flag, A < B.
REQ-010 out_valid  output  1  high once the flags hold a sampled comparison.
REQ-011 eq_count  output  CNT_W  number of sampled equal outcomes.
REQ-012 gt_count  output  CNT_W  number of sampled greater outcomes.
REQ-013 lt_count  output  CNT_W  number of sampled less outcomes.

Function
REQ-014 Compare logic SHALL be gate-level primitives only:
- equal = XNOR(A,B)
- greater = AND(A, NOT B)
- less = AND(NOT A, B)
REQ-015 The three results SHALL be registered on every rising clk edge when rst is low; latency exactly 1 cycle from A/B to flags.
REQ-016 When out_valid is high, exactly one of the three flags SHALL be high (one-hot).
REQ-017 Truth table of registered flags (eq, gt, lt), by input (A,B):
- (0,0) -> 1,0,0
- (0,1) -> 0,0,1
- (1,0) -> 0,1,0
- (1,1) -> 1,0,0
REQ-018 out_valid SHALL rise on the first rising edge after rst deasserts and stay high until the next reset.
REQ-019 Counting: on each rising edge with rst low, the counter matching the combinational outcome of the current A/B SHALL increment by 1; the other two counters SHALL hold.
REQ-020 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 cnt_clr high at a rising edge SHALL set all three counters to 0, overriding any simultaneous increment; flags and out_valid are unaffected by cnt_clr.
REQ-022 The sum eq_count+gt_count+lt_count SHALL equal the number of sampled edges since the last reset or clear, as long as no counter is saturated.
REQ-023 A/B changes between clock edges SHALL have no effect on outputs until the next rising edge.

Reset
REQ-024 While rst is high, all of the following SHALL be 0 immediately, without waiting for clk:
- A_equals_B, A_greater_B, A_less_B
- out_valid
- eq_count, gt_count, lt_count
REQ-025 Reset asserted mid-operation SHALL clear all state asynchronously; the first rising edge after deassertion samples A/B normally.
REQ-026 During reset no flag is high, so the one-hot rule (REQ-016) applies only when out_valid=1.

Verification
REQ-027 Reset then A=0,B=0, one edge -> eq=1,gt=0,lt=0, out_valid=1, eq_count=1.
REQ-028 Sequence (0,0),(0,1),(1,0),(1,1), one edge each -> flags 100,001,010,100 each one cycle after the input; final counts eq=2, gt=1, lt=1.
REQ-029 CNT_W=2, hold A=1,B=0 for 5 edges -> gt_count=3 (saturated); eq_count=0, lt_count=0.
REQ-030 cnt_clr=1 with A=0,B=1 on the same edge -> all counts 0 after the edge; A_less_B=1.
REQ-031 Assert rst between edges while flags=010 and counts nonzero -> all outputs 0 before the next edge; after release, the first edge gives valid flags and count=1 for the sampled outcome.
REQ-032 Toggle A between edges without an edge -> flags and counts unchanged.
